// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin, burst-locking arbiter sharing one BRAM port among NREQ requesters
module bram_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [ADDR_W-1:0]      bram_addr,
    output logic [DATA_W-1:0]      bram_din,
    output logic                   bram_we,
    input  logic [DATA_W-1:0]      bram_dout
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state;
    logic [PW-1:0]     rr_ptr, owner, win, sel;
    logic              has_sel, accept;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[PW'((int'(rr_ptr) + k) % NREQ)]) win = PW'((int'(rr_ptr) + k) % NREQ);
    end

    assign sel       = (state == BURST) ? owner : win;
    assign has_sel   = (state == BURST) ? req_valid[owner] : |req_valid;
    assign accept    = has_sel && !rst;
    assign req_ready = accept ? NREQ'(1) << sel : '0;
    assign bram_we   = accept && req_we[sel];
    assign bram_addr = has_sel ? addr_a[sel] : addr_q;
    assign bram_din  = data_a[sel];
    assign rsp_rdata = bram_dout;

    always_ff @(posedge clk) addr_q <= bram_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= req_ready & ~req_we;
            if (accept) begin
                state <= req_last[sel] ? IDLE : BURST;
                owner <= sel;
                if (req_last[sel]) rr_ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of arbitration, bursts, read responses and reset
module tb_bram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 256;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      valid, we, last, ready, rsp_valid;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [DW-1:0]   rsp_rdata, bram_din, bram_dout;
    logic [AW-1:0]   bram_addr;
    logic            bram_we;
    logic [DW-1:0]   mem [1024];

    logic [2:0]      v3, we3, last3, ready3, rsp3;
    logic [3*AW-1:0] a3;
    logic [3*DW-1:0] d3;
    logic [DW-1:0]   rd3, din3, dout3;
    logic [AW-1:0]   ba3;
    logic            bwe3;

    int checks = 0;
    int errors = 0;

    bram_port_arbiter #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_we(we), .req_last(last),
        .req_addr(addr), .req_wdata(wdata), .req_ready(ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_we(bram_we), .bram_dout(bram_dout)
    );

    bram_port_arbiter #(.NREQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_we(we3), .req_last(last3),
        .req_addr(a3), .req_wdata(d3), .req_ready(ready3), .rsp_valid(rsp3),
        .rsp_rdata(rd3), .bram_addr(ba3), .bram_din(din3),
        .bram_we(bwe3), .bram_dout(dout3)
    );

    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    function automatic logic [DW-1:0] init_word(int a);
        return DW'(a + 32'h1000);
    endfunction

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, logic v, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
        valid[i]           = v;
        we[i]              = w;
        last[i]            = l;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic [1:0]    g;
        logic [2:0]    e3;
        a5 = {32{8'hA5}};
        for (int a = 0; a < 1024; a++) mem[a] = init_word(a);
        valid = '0; we = '0; last = '0; addr = '0; wdata = '0;
        v3 = '0; we3 = '0; last3 = '1; a3 = '0; d3 = '0; dout3 = '0;

        // reset forces ready and we low even with pending writes
        drive(0, 1, 1, 1, 1, a5);
        drive(1, 1, 1, 1, 2, a5);
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_we", bram_we, 0);
        tick();
        check("rst_rsp", rsp_valid, 0);
        valid = '0;
        rst = 1'b0;

        // write then read of the same address
        drive(0, 1, 1, 1, 5, a5);
        @(negedge clk);
        check("t1_wr_ready", ready, 2'b01);
        check("t1_wr_we", bram_we, 1);
        check("t1_wr_addr", bram_addr, 5);
        check("t1_wr_din", bram_din, a5);
        tick();
        drive(0, 1, 0, 1, 5, '0);
        @(negedge clk);
        check("t1_rd_ready", ready, 2'b01);
        check("t1_rd_we", bram_we, 0);
        tick();
        check("t1_rsp", rsp_valid, 2'b01);
        check("t1_rdata", rsp_rdata, a5);
        valid = '0;
        @(negedge clk);
        check("t1_idle_ready", ready, 0);
        check("t1_addr_hold", bram_addr, 5);
        tick();
        check("t1_rsp_once", rsp_valid, 0);

        // rr_ptr is 1: alternating grants starting with req1
        drive(0, 1, 1, 1, 10, {8{32'hDEADBEEF}});
        drive(1, 1, 0, 1, 11, '0);
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            check("t2_ready", ready, g);
            check("t2_we", bram_we, g[0]);
            tick();
            check("t2_rsp", rsp_valid, g[1] ? 2'b10 : 2'b00);
            if (g[1]) check("t2_rdata", rsp_rdata, init_word(11));
        end
        valid = '0;

        // req1 4-beat read burst locks out req0
        drive(0, 1, 0, 1, 30, '0);
        for (int b = 0; b < 4; b++) begin
            drive(1, 1, 0, b == 3, AW'(20 + b), '0);
            @(negedge clk);
            check("t3_ready", ready, 2'b10);
            tick();
            check("t3_rsp", rsp_valid, 2'b10);
            check("t3_rdata", rsp_rdata, init_word(20 + b));
        end
        valid[1] = 1'b0;
        @(negedge clk);
        check("t3_req0_ready", ready, 2'b01);
        tick();
        check("t3_req0_rsp", rsp_valid, 2'b01);
        check("t3_req0_rdata", rsp_rdata, init_word(30));
        valid = '0;

        // owner stalls mid-burst; req0 must wait
        drive(0, 1, 0, 1, 31, '0);
        drive(1, 1, 0, 0, 40, '0);
        @(negedge clk);
        check("t4_b1_ready", ready, 2'b10);
        tick();
        check("t4_b1_rsp", rsp_valid, 2'b10);
        check("t4_b1_rdata", rsp_rdata, init_word(40));
        valid[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t4_stall_ready", ready, 0);
            check("t4_stall_we", bram_we, 0);
            tick();
            check("t4_stall_rsp", rsp_valid, 0);
        end
        drive(1, 1, 0, 1, 41, '0);
        @(negedge clk);
        check("t4_b2_ready", ready, 2'b10);
        tick();
        check("t4_b2_rsp", rsp_valid, 2'b10);
        check("t4_b2_rdata", rsp_rdata, init_word(41));
        valid[1] = 1'b0;
        @(negedge clk);
        check("t4_req0_ready", ready, 2'b01);
        tick();
        check("t4_req0_rdata", rsp_rdata, init_word(31));
        valid = '0;

        // reset during a req1 burst restarts arbitration at req0
        drive(1, 1, 0, 0, 50, '0);
        @(negedge clk);
        check("t5_b1_ready", ready, 2'b10);
        tick();
        drive(1, 1, 0, 0, 51, '0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", ready, 0);
        tick();
        check("t5_rst_rsp", rsp_valid, 0);
        rst = 1'b0;
        drive(0, 1, 0, 1, 60, '0);
        drive(1, 1, 0, 1, 61, '0);
        @(negedge clk);
        check("t5_grant", ready, 2'b01);
        tick();
        check("t5_rsp", rsp_valid, 2'b01);
        check("t5_rdata", rsp_rdata, init_word(60));
        valid = '0;

        // three requesters: pointer wraps from 2 back to 0
        v3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            e3 = 3'b001 << (k % 3);
            @(negedge clk);
            check("t6_ready", ready3, e3);
            tick();
            check("t6_rsp", rsp3, e3);
        end
        v3 = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
